// File: rtl/time_pkg.sv
// -----------------------------------------------------------------------------
// time_pkg
// Shared constants, the operating-mode enum and the 12 h display formatter for
// the timekeeping datapath (time_counter and its mod_counter digits).
// -----------------------------------------------------------------------------
package time_pkg;

  localparam int HOURS_MAX = 23;
  localparam int MINS_MAX  = 59;
  localparam int SECS_MAX  = 59;
  localparam int HOUR_W    = 5;
  localparam int MIN_W     = 6;
  localparam int SEC_W     = 6;

  // Effective operating mode seen by the datapath. Run wins over both set
  // modes, and hour-set wins over minute-set.
  typedef enum logic [1:0] {
    MODE_IDLE = 2'd0,
    MODE_RUN  = 2'd1,
    MODE_HSET = 2'd2,
    MODE_MSET = 2'd3
  } mode_e;

  function automatic mode_e decode_mode(input logic clockon,
                                        input logic hset,
                                        input logic mset);
    mode_e m;
    if (clockon)   m = MODE_RUN;
    else if (hset) m = MODE_HSET;
    else if (mset) m = MODE_MSET;
    else           m = MODE_IDLE;
    return m;
  endfunction

  // Returns {pm, disp_hour} for the 12 h display: 0 and 12 show as 12,
  // afternoon hours drop by 12, morning hours pass through.
  function automatic logic [HOUR_W:0] fmt_12h(input logic [HOUR_W-1:0] hour);
    logic              pm;
    logic [HOUR_W-1:0] disp;
    pm = (hour >= HOUR_W'(12));
    if (hour == HOUR_W'(0) || hour == HOUR_W'(12)) disp = HOUR_W'(12);
    else if (hour > HOUR_W'(12))                   disp = hour - HOUR_W'(12);
    else                                           disp = hour;
    return {pm, disp};
  endfunction

endpackage

// File: rtl/mod_counter.sv
// -----------------------------------------------------------------------------
// mod_counter
// One wrapping digit of the time-of-day register (seconds, minutes or hours).
// Counts 0..MAX, wrapping MAX -> 0 by compare-and-reset.
//
// Ports
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset, clears q
//   en     in   advance by one this cycle
//   clr    in   synchronous clear to 0 (wins over en)
//   q      out  registered count
//   carry  out  en while q==MAX, i.e. this advance wraps the digit
// -----------------------------------------------------------------------------
module mod_counter #(
  parameter int MAX = 59,
  parameter int W   = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] q,
  output logic         carry
);

  logic [W-1:0] q_q, q_d;
  logic         at_max;

  assign at_max = (q_q == W'(MAX));
  assign carry  = en & at_max;
  assign q      = q_q;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    q_d = q_q;
    if (clr)         q_d = '0;
    else if (en)     q_d = at_max ? '0 : q_q + W'(1);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

endmodule

// File: rtl/time_counter.sv
// -----------------------------------------------------------------------------
// time_counter
// Hours:minutes:seconds timekeeping datapath downstream of the clock/calendar
// mode FSM. A prescaler divides clk down to a one-per-second tick while
// clockon=1; in set mode (clockon=0) a rising edge of inc bumps the hour
// (hset) or the minute (mset, clearing seconds) without carry. A registered
// day_tick pulses for the first cycle the outputs read 00:00:00 after a
// natural midnight rollover. The display hour is formatted combinationally
// for 12 h or 24 h mode.
//
// Build option
//   AUTOREPEAT_EN  when defined, a held inc keeps incrementing: after
//                  REPEAT_DLY prescaler periods (REPEAT_DLY*TICK_DIV cycles,
//                  counted from the press) one further increment every
//                  REPEAT_PER cycles. When undefined no repeat logic exists.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   clockon    in   run enable; time advances only when 1
//   hset       in   hour-set mode
//   mset       in   minute-set mode
//   inc        in   debounced increment button (level)
//   h1224      in   display format, 1 = 12 h, 0 = 24 h
//   hour       out  registered hours 0..23
//   minute     out  registered minutes 0..59
//   second     out  registered seconds 0..59
//   disp_hour  out  formatted hour for the display mux
//   pm         out  PM indicator (12 h mode only)
//   day_tick   out  one-cycle pulse after midnight rollover
// -----------------------------------------------------------------------------
module time_counter
  import time_pkg::*;
#(
  parameter int TICK_DIV   = 50000000,
  parameter int REPEAT_DLY = 2,
  parameter int REPEAT_PER = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clockon,
  input  logic              hset,
  input  logic              mset,
  input  logic              inc,
  input  logic              h1224,
  output logic [HOUR_W-1:0] hour,
  output logic [MIN_W-1:0]  minute,
  output logic [SEC_W-1:0]  second,
  output logic [HOUR_W-1:0] disp_hour,
  output logic              pm,
  output logic              day_tick
);

  if (TICK_DIV < 2 || REPEAT_DLY < 1 || REPEAT_PER < 1) begin : g_cfg_check
    $error("time_counter: TICK_DIV must be >= 2, REPEAT_DLY and REPEAT_PER >= 1");
  end

  localparam int PRE_W = $clog2(TICK_DIV);

  mode_e mode;
  logic  run_mode;
  logic  set_mode;

  assign mode     = decode_mode(clockon, hset, mset);
  assign run_mode = (mode == MODE_RUN);
  assign set_mode = (mode == MODE_HSET) || (mode == MODE_MSET);

  // ---------------------------------------------------------------------------
  // Seconds prescaler: free-counts while running, parked at 0 otherwise, so
  // the first tick always lands TICK_DIV cycles after clockon rises.
  // ---------------------------------------------------------------------------
  logic [PRE_W-1:0] presc_q, presc_d;
  logic             sec_tick;

  assign sec_tick = run_mode && (presc_q == PRE_W'(TICK_DIV - 1));

  always_comb begin
    presc_d = '0;
    if (run_mode && !sec_tick) presc_d = presc_q + PRE_W'(1);
  end

  // ---------------------------------------------------------------------------
  // Increment events: rising edge of inc, plus auto-repeat when built in.
  // ---------------------------------------------------------------------------
  logic inc_q;
  logic inc_rise;
  logic inc_evt;

  assign inc_rise = inc & ~inc_q;

`ifdef AUTOREPEAT_EN
  // rep_cnt_q counts cycles since the press while inc stays high in one set
  // mode. It fires at REP_FIRE, then reloads to REP_HOLD so each further
  // pulse comes REPEAT_PER cycles later.
  localparam int REP_HOLD = REPEAT_DLY * TICK_DIV;
  localparam int REP_FIRE = REP_HOLD + REPEAT_PER;
  localparam int REP_W    = $clog2(REP_FIRE + 1);

  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  mode_e            mode_q;
  logic             rep_pulse;

  always_comb begin
    rep_cnt_d = rep_cnt_q;
    rep_pulse = 1'b0;
    if (!inc || !set_mode || (mode != mode_q)) begin
      rep_cnt_d = '0;
    end else if (rep_cnt_q == REP_W'(REP_FIRE)) begin
      rep_pulse = 1'b1;
      rep_cnt_d = REP_W'(REP_HOLD);
    end else begin
      rep_cnt_d = rep_cnt_q + REP_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rep_cnt_q <= '0;
      mode_q    <= MODE_IDLE;
    end else begin
      rep_cnt_q <= rep_cnt_d;
      mode_q    <= mode;
    end
  end

  assign inc_evt = inc_rise | rep_pulse;
`else
  assign inc_evt = inc_rise;
`endif

  logic hour_set;
  logic min_set;

  assign hour_set = (mode == MODE_HSET) && inc_evt;
  assign min_set  = (mode == MODE_MSET) && inc_evt;

  // ---------------------------------------------------------------------------
  // Time-of-day digits. Set-mode bumps drive en directly; carries into the
  // next digit and into day_tick are only honoured in run mode.
  // ---------------------------------------------------------------------------
  logic sec_carry;
  logic min_carry;
  logic hour_carry;

  mod_counter #(.MAX(SECS_MAX), .W(SEC_W)) u_sec (
    .clk   (clk),
    .rst_n (reset),
    .en    (sec_tick),
    .clr   (min_set),
    .q     (second),
    .carry (sec_carry)
  );

  mod_counter #(.MAX(MINS_MAX), .W(MIN_W)) u_min (
    .clk   (clk),
    .rst_n (reset),
    .en    (sec_carry | min_set),
    .clr   (1'b0),
    .q     (minute),
    .carry (min_carry)
  );

  mod_counter #(.MAX(HOURS_MAX), .W(HOUR_W)) u_hour (
    .clk   (clk),
    .rst_n (reset),
    .en    ((min_carry & run_mode) | hour_set),
    .clr   (1'b0),
    .q     (hour),
    .carry (hour_carry)
  );

  logic day_tick_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q    <= '0;
      inc_q      <= 1'b0;
      day_tick_q <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      inc_q      <= inc;
      // Registered on the rollover edge, so it is high exactly while the
      // digits first read 00:00:00.
      day_tick_q <= hour_carry & run_mode;
    end
  end

  assign day_tick = day_tick_q;

  // ---------------------------------------------------------------------------
  // Display formatting from the registered hour.
  // ---------------------------------------------------------------------------
  logic [HOUR_W:0] fmt;

  assign fmt            = h1224 ? fmt_12h(hour) : {1'b0, hour};
  assign {pm, disp_hour} = fmt;

endmodule
